// File: rtl/gpio_pin_debounce_pkg.sv
// gpio_pkg: shared constants and helpers for the GPIO input front end.
//   GPIO_WIDTH           - number of chip-edge input pins
//   SYNC_STAGES_DEF      - default synchroniser depth (legal 2..4)
//   DEBOUNCE_CYCLES_DEF  - default number of consecutive differing cycles to accept a change
//   debounce_cnt_width() - width of the per-bit debounce counter
package gpio_pkg;

  localparam int GPIO_WIDTH          = 32;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // One extra bit over $clog2 so that DEBOUNCE_CYCLES=1 still yields a 1-bit counter.
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/gpio_pin_debounce_if.sv
// gpio_pin_debounce_if: signal bundle between the pin front end and its user.
//   master: drives pins_async, snap_req, rise_en, fall_en, flag_clr;
//           receives din_out, din_valid, rise_flags, fall_flags, irq
//   slave : the debounce block (directions reversed)
interface gpio_pin_debounce_if #(
  parameter int WIDTH = gpio_pkg::GPIO_WIDTH
);

  logic [WIDTH-1:0] pins_async;
  logic             snap_req;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] din_out;
  logic             din_valid;
  logic [WIDTH-1:0] rise_flags;
  logic [WIDTH-1:0] fall_flags;
  logic             irq;

  modport master (
    output pins_async, snap_req, rise_en, fall_en, flag_clr,
    input  din_out, din_valid, rise_flags, fall_flags, irq
  );

  modport slave (
    input  pins_async, snap_req, rise_en, fall_en, flag_clr,
    output din_out, din_valid, rise_flags, fall_flags, irq
  );

endinterface

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: synchroniser plus debouncer for one input pin.
//   clk, reset     - system clock, synchronous active-high reset
//   i_pin_async    - raw pin level, asynchronous to clk
//   o_stable       - debounced level
//   o_rise_pulse   - high in the cycle whose edge moves o_stable 0->1
//   o_fall_pulse   - high in the cycle whose edge moves o_stable 1->0
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin_async,
  output logic o_stable,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);

  localparam int            CW       = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;

  logic w_sync_q;
  logic w_differ;
  logic w_accept;

  // Plain shift chain: nothing sits between the flops, so the metastability
  // settling time of each stage is a full clock period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin_async};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_differ = w_sync_q ^ r_stable;
  // The counter has already seen DEBOUNCE_CYCLES-1 differing samples; this is the last one.
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  // Counter saturates at CNT_LAST by construction: reaching it either accepts or restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_differ) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_stable <= w_sync_q;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable     = r_stable;
  assign o_rise_pulse = w_accept & w_sync_q;
  assign o_fall_pulse = w_accept & ~w_sync_q;

endmodule

// File: rtl/gpio_pin_debounce.sv
// gpio_pin_debounce: general-purpose input front end.
//   clk, reset        - system clock, synchronous active-high reset
//   bus (slave)       - pins_async in, snap_req in, rise_en/fall_en irq masks,
//                       flag_clr W1C strobe; din_out stable word (edge byte
//                       order, unswapped), din_valid one-cycle strobe,
//                       sticky rise_flags/fall_flags, registered irq
module gpio_pin_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  gpio_pin_debounce_if.slave bus
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise_pulse;
  logic [WIDTH-1:0] w_fall_pulse;

  logic             r_din_valid;
  logic [WIDTH-1:0] r_rise_flags;
  logic [WIDTH-1:0] r_fall_flags;
  logic             r_irq;

  logic             w_any_change;
  logic [WIDTH-1:0] w_rise_flags_next;
  logic [WIDTH-1:0] w_fall_flags_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      gpio_debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
        .clk          (clk),
        .reset        (reset),
        .i_pin_async  (bus.pins_async[gi]),
        .o_stable     (w_stable[gi]),
        .o_rise_pulse (w_rise_pulse[gi]),
        .o_fall_pulse (w_fall_pulse[gi])
      );
    end
  endgenerate

  // Any number of bits settling together, with or without snap_req, yields one strobe.
  assign w_any_change = |(w_rise_pulse | w_fall_pulse);

  // Clear first, then OR in new edges, so a set on the clearing edge survives.
  assign w_rise_flags_next = (r_rise_flags & ~bus.flag_clr) | w_rise_pulse;
  assign w_fall_flags_next = (r_fall_flags & ~bus.flag_clr) | w_fall_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_din_valid  <= 1'b0;
      r_rise_flags <= '0;
      r_fall_flags <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_din_valid  <= w_any_change | bus.snap_req;
      r_rise_flags <= w_rise_flags_next;
      r_fall_flags <= w_fall_flags_next;
      // Built from the flag registers, so irq trails a flag edge by one cycle
      // while following mask changes with a single-cycle delay.
      r_irq        <= |((r_rise_flags & bus.rise_en) | (r_fall_flags & bus.fall_en));
    end
  end

  assign bus.din_out    = w_stable;
  assign bus.din_valid  = r_din_valid;
  assign bus.rise_flags = r_rise_flags;
  assign bus.fall_flags = r_fall_flags;
  assign bus.irq        = r_irq;

endmodule
